// File: rtl/ctr_if.sv
// Opcode-in / control-strobes-out bundle of the MIPS main control decoder.
// The decode source (fetch/decode stage) drives op; the decoder drives the strobes.
interface ctr_if;
   logic [5:0] op;
   logic       RegDst;
   logic       Jump;
   logic       Branch;
   logic       MemRead;
   logic       MemtoReg;
   logic [1:0] ALUOp;
   logic       MemWrite;
   logic       ALUSrc;
   logic       RegWrite;
   logic       Illegal;

   modport master (
      output op,
      input  RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp,
      input  MemWrite, ALUSrc, RegWrite, Illegal
   );

   modport slave (
      input  op,
      output RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp,
      output MemWrite, ALUSrc, RegWrite, Illegal
   );
endinterface : ctr_if

// File: rtl/ctr.sv
// Registered main control decoder for a single-cycle MIPS datapath (one clock op-to-controls).
// Optional macro CTR_ADDI_EN adds addi support; without it addi decodes as illegal.
module ctr (
   input  logic  clock,
   input  logic  reset_n,
   ctr_if.slave  bus
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef CTR_ADDI_EN
   localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic [1:0] alu_op;
      logic       illegal;
   } ctrl_t;

   ctrl_t ctrl_d;
   ctrl_t ctrl_q;

   // Opcode decode; unlisted opcodes fall to a safe NOP flagged as illegal.
   always_comb begin
      ctrl_d = '0;
      case (bus.op)
         OP_RTYPE: begin
            ctrl_d.reg_dst   = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_op    = ALUOP_FUNCT;
         end
         OP_LW: begin
            ctrl_d.alu_src    = 1'b1;
            ctrl_d.mem_to_reg = 1'b1;
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.mem_read   = 1'b1;
            ctrl_d.alu_op     = ALUOP_ADD;
         end
         OP_SW: begin
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.mem_write = 1'b1;
            ctrl_d.alu_op    = ALUOP_ADD;
         end
         OP_BEQ: begin
            ctrl_d.branch = 1'b1;
            ctrl_d.alu_op = ALUOP_SUB;
         end
         OP_J: begin
            ctrl_d.jump   = 1'b1;
            ctrl_d.alu_op = ALUOP_ADD;
         end
`ifdef CTR_ADDI_EN
         OP_ADDI: begin
            ctrl_d.alu_src   = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_op    = ALUOP_ADD;
         end
`endif
         default: begin
            ctrl_d         = '0;
            ctrl_d.illegal = 1'b1;
         end
      endcase
   end

   // Output register; reset clears every strobe and wins over decode.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ctrl_q <= '0;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   assign bus.RegDst   = ctrl_q.reg_dst;
   assign bus.ALUSrc   = ctrl_q.alu_src;
   assign bus.MemtoReg = ctrl_q.mem_to_reg;
   assign bus.RegWrite = ctrl_q.reg_write;
   assign bus.MemRead  = ctrl_q.mem_read;
   assign bus.MemWrite = ctrl_q.mem_write;
   assign bus.Branch   = ctrl_q.branch;
   assign bus.Jump     = ctrl_q.jump;
   assign bus.ALUOp    = ctrl_q.alu_op;
   assign bus.Illegal  = ctrl_q.illegal;

endmodule : ctr

// File: tb/tb_ctr.sv
// Self-checking bench for ctr: directed scenarios plus randomized opcodes/resets against a table model.
// Vector order everywhere: {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,ALUOp[1:0],Illegal}.
module tb_ctr;

   logic clock;
   logic reset_n;
   int   checks;
   int   errors;

   logic [10:0] tbl [logic [5:0]];

   ctr_if bus ();

   ctr u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [10:0] observed();
      return {bus.RegDst, bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemRead,
              bus.MemWrite, bus.Branch, bus.Jump, bus.ALUOp, bus.Illegal};
   endfunction

   // Reference: decode table lookup; anything absent is the illegal NOP.
   function automatic logic [10:0] model(input logic [5:0] op, input logic rst_active);
      if (rst_active) return 11'b0;
      if (tbl.exists(op)) return tbl[op];
      return 11'b000_0000_0001;
   endfunction

   task automatic tick(input logic [5:0] op, input logic rn);
      bus.op  = op;
      reset_n = rn;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [10:0] o;
      tick(6'b000000, 1'b0);
      tick(6'b000000, 1'b0);
      o = observed();
      checks++;
      if (o !== 11'b0) begin
         errors++;
         $display("FAIL reset_hold got=%b want=%b", o, 11'b0);
      end
      tick(6'b000000, 1'b1);
      o = observed();
      checks++;
      if (o !== 11'b1001_0000_100) begin
         errors++;
         $display("FAIL reset_release_rtype got=%b want=%b", o, 11'b1001_0000_100);
      end
   endtask

   task automatic test_decode_table();
      logic [5:0]  ops [5];
      logic [10:0] want [5];
      logic [10:0] o;
      ops[0] = 6'b000000; want[0] = 11'b1001_0000_100;
      ops[1] = 6'b000010; want[1] = 11'b0000_0001_000;
      ops[2] = 6'b000100; want[2] = 11'b0000_0010_010;
      ops[3] = 6'b101011; want[3] = 11'b0100_0100_000;
      ops[4] = 6'b100011; want[4] = 11'b0111_1000_000;
      for (int i = 0; i < 5; i++) begin
         tick(ops[i], 1'b1);
         o = observed();
         checks++;
         if (o !== want[i]) begin
            errors++;
            $display("FAIL decode_op_%b got=%b want=%b", ops[i], o, want[i]);
         end
      end
   endtask

   task automatic test_latency();
      logic [10:0] o;
      tick(6'b100011, 1'b1);
      bus.op = 6'b000010;
      #3;
      o = observed();
      checks++;
      if (o !== 11'b0111_1000_000) begin
         errors++;
         $display("FAIL latency_hold got=%b want=%b", o, 11'b0111_1000_000);
      end
      @(posedge clock);
      #1;
      o = observed();
      checks++;
      if (o !== 11'b0000_0001_000) begin
         errors++;
         $display("FAIL latency_update got=%b want=%b", o, 11'b0000_0001_000);
      end
   endtask

   task automatic test_illegal();
      logic [5:0]  ops [3];
      logic [10:0] want [3];
      logic [10:0] o;
      ops[0] = 6'b111111; want[0] = 11'b000_0000_0001;
      ops[1] = 6'b000011; want[1] = 11'b000_0000_0001;
      ops[2] = 6'b100011; want[2] = 11'b0111_1000_000;
      for (int i = 0; i < 3; i++) begin
         tick(ops[i], 1'b1);
         o = observed();
         checks++;
         if (o !== want[i]) begin
            errors++;
            $display("FAIL illegal_op_%b got=%b want=%b", ops[i], o, want[i]);
         end
      end
   endtask

   task automatic test_addi();
      logic [10:0] o;
      logic [10:0] want;
`ifdef CTR_ADDI_EN
      want = 11'b0101_0000_000;
`else
      want = 11'b000_0000_0001;
`endif
      tick(6'b001000, 1'b1);
      o = observed();
      checks++;
      if (o !== want) begin
         errors++;
         $display("FAIL addi got=%b want=%b", o, want);
      end
   endtask

   task automatic test_reset_mid();
      logic [10:0] o;
      tick(6'b100011, 1'b1);
      tick(6'b100011, 1'b0);
      o = observed();
      checks++;
      if (o !== 11'b0) begin
         errors++;
         $display("FAIL reset_mid_clear got=%b want=%b", o, 11'b0);
      end
      tick(6'b100011, 1'b1);
      o = observed();
      checks++;
      if (o !== 11'b0111_1000_000) begin
         errors++;
         $display("FAIL reset_mid_release got=%b want=%b", o, 11'b0111_1000_000);
      end
   endtask

   task automatic test_random();
      logic [5:0]  known [6];
      logic [5:0]  op;
      logic        rn;
      logic [10:0] o;
      logic [10:0] want;
      known[0] = 6'b000000; known[1] = 6'b000010; known[2] = 6'b000100;
      known[3] = 6'b100011; known[4] = 6'b101011; known[5] = 6'b001000;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(1, 0) == 1) op = known[$urandom_range(5, 0)];
         else                           op = 6'($urandom);
         rn = ($urandom_range(9, 0) != 0);
         want = model(op, !rn);
         tick(op, rn);
         o = observed();
         checks++;
         if (o !== want) begin
            errors++;
            $display("FAIL random_%0d op=%b rn=%b got=%b want=%b", i, op, rn, o, want);
         end
         checks++;
         if (((bus.MemRead & bus.MemWrite) | (bus.Branch & bus.Jump) |
              (bus.RegWrite & bus.MemWrite)) !== 1'b0) begin
            errors++;
            $display("FAIL exclusivity_%0d got=%b want=no conflicting strobes", i, o);
         end
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      bus.op  = 6'b000000;
      tbl[6'b000000] = 11'b1001_0000_100;
      tbl[6'b100011] = 11'b0111_1000_000;
      tbl[6'b101011] = 11'b0100_0100_000;
      tbl[6'b000100] = 11'b0000_0010_010;
      tbl[6'b000010] = 11'b0000_0001_000;
`ifdef CTR_ADDI_EN
      tbl[6'b001000] = 11'b0101_0000_000;
`endif
      test_reset();
      test_decode_table();
      test_latency();
      test_illegal();
      test_addi();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_ctr

// File: doc/ctr.md
Name: ctr

Overview:
- Main control decoder for a single-cycle-style MIPS datapath.
- Decodes the 6-bit instruction opcode into the datapath control strobes and the 2-bit ALUOp consumed by the ALU-control block.
- All outputs are registered: one clock of latency from `op` to controls.
- Sits between instruction fetch/decode and the register file, ALU, data memory and PC-select muxes.

Parameters:
- None. Opcode encodings are fixed MIPS-I values as local constants: R-type 6'b000000, j 6'b000010, beq 6'b000100, lw 6'b100011, sw 6'b101011, addi 6'b001000.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous reset, active low.
- op  input  6  instruction opcode field (instr[31:26]).
- RegDst  output  1  1 = write-register number is rd; 0 = rt.
- Jump  output  1  1 = PC takes the jump target.
- Branch  output  1  1 = conditional branch (ANDed with ALU zero outside this block).
- MemRead  output  1  data-memory read enable.
- MemtoReg  output  1  1 = register write data from memory; 0 = from ALU.
- ALUOp  output  2  00 = add, 01 = subtract (compare), 10 = use funct field.
- MemWrite  output  1  data-memory write enable.
- ALUSrc  output  1  1 = ALU B operand is the sign-extended immediate; 0 = rt.
- RegWrite  output  1  register-file write enable.
- Illegal  output  1  1 = opcode not supported in this build.

Behaviour:
- All outputs are registered and update on the rising edge of clock. Latency is exactly 1 cycle: controls for `op` sampled at edge N are visible after edge N. No handshake; `op` is sampled every cycle.
- Synchronous reset: when reset_n=0 at a rising edge, every output goes to 0 (ALUOp=00, Illegal=0). Reset has priority over decode. Reset asserted mid-stream discards the pending decode, and outputs read 0 on the next edge.
- Decode table, with bits listed as RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp:
  - R-type: 1,0,0,1,0,0,0,0,10
  - lw: 0,1,1,1,1,0,0,0,00
  - sw: 0,1,0,0,0,1,0,0,00
  - beq: 0,0,0,0,0,0,1,0,01
  - j: 0,0,0,0,0,0,0,1,00
- Don't-care fields (RegDst and MemtoReg for sw/beq/j) are driven to 0 so the outputs are fully deterministic.
- Any other opcode (including addi when the optional feature is disabled):
  - All control outputs 0 (a safe NOP: no register write, no memory access, no PC change).
  - ALUOp=00, Illegal=1.
- Illegal=0 for every supported opcode.
- At most one of MemRead/MemWrite, and at most one of Branch/Jump, is 1 in any cycle. RegWrite and MemWrite are never both 1.
- Outputs hold their value while `op` is unchanged. No internal state beyond the output registers.

Optional Feature:
- Macro CTR_ADDI_EN.
- Defined: opcode 6'b001000 (addi) is supported and decodes to RegDst=0, ALUSrc=1, MemtoReg=0, RegWrite=1, MemRead=0, MemWrite=0, Branch=0, Jump=0, ALUOp=00, Illegal=0.
- Not defined: 6'b001000 is treated as illegal (all controls 0, Illegal=1).
- All other opcodes behave identically in both builds.

Test Plan:
- Reset: reset_n=0 for 2 edges with op=6'b000000 → after the edge all outputs 0 and Illegal=0. Release reset_n=1 → next edge gives the R-type vector RegDst=1, RegWrite=1, ALUOp=10, all others 0.
- Sequence op=000000, 000010, 000100, 101011, 100011, one per clock → each row of the decode table appears exactly one edge after its op (j: Jump=1; beq: Branch=1, ALUOp=01; sw: ALUSrc=1, MemWrite=1; lw: ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1).
- Latency: change op between edges → outputs unchanged until the next rising edge, then show the new decode; no combinational path from op to outputs.
- Illegal opcodes 6'b111111 and 6'b000011 → all controls 0, ALUOp=00, Illegal=1. Following op=100011 → Illegal returns to 0 with the lw vector.
- op=6'b001000: with CTR_ADDI_EN → ALUSrc=1, RegWrite=1, ALUOp=00, Illegal=0. Without it → all 0, Illegal=1.
- Reset mid-run: op=100011 steady, pulse reset_n=0 for one edge → outputs 0 on that edge, then the lw vector on the first edge after release.
